// File: rtl/usb_fs_receiver_pkg.sv
// Shared definitions for the USB full-speed receive front end: line-state
// encodings, receiver FSM states, bus timing defaults and PID constants.
package usb_fs_receiver_pkg;

    // Synchronized line state as {D+, D-}
    typedef enum logic [1:0] {
        LS_SE0 = 2'b00,
        LS_K   = 2'b01,
        LS_J   = 2'b10,
        LS_SE1 = 2'b11
    } line_state_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC  = 3'd1,
        ST_DATA  = 3'd2,
        ST_EOP   = 3'd3,
        ST_ABORT = 3'd4
    } rx_state_e;

    // 2.5 us of SE0 at 48 MHz marks a bus reset
    localparam int RESET_CYCLES_DEFAULT   = 120;
    // Decoded zeros needed ahead of the SYNC-terminating one
    localparam int MIN_SYNC_ZEROS_DEFAULT = 5;

    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;
    localparam logic [7:0] PID_STALL = 8'h1E;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;

    // NRZI: an unchanged line level decodes as 1, a transition as 0
    function automatic logic nrzi_decode(input line_state_e cur, input line_state_e prev);
        return (cur == prev);
    endfunction

endpackage

// File: rtl/usb_fs_receiver_if.sv
// Receive-side bundle from the front end to the packet decoder.
interface usb_fs_receiver_if;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       packet_start;
    logic       packet_end;
    logic       packet_error;
    logic       bus_reset;

    modport master (
        output byte_data, byte_valid, packet_start, packet_end, packet_error, bus_reset
    );

    modport slave (
        input byte_data, byte_valid, packet_start, packet_end, packet_error, bus_reset
    );
endinterface

// File: rtl/usb_fs_receiver_line_sampler.sv
// Line sampler: two-flop synchronizers on D+/D-, line-state decode and the
// 4x oversampling phase counter that picks the mid-bit sample point.
module usb_line_sampler
    import usb_fs_receiver_pkg::*;
(
    input  logic        clock48,
    input  logic        reset,
    input  logic        data_p,
    input  logic        data_n,
    output line_state_e line_state,
    output logic        sample_strobe
);

    logic [1:0] sync1_q, sync1_d;
    logic [1:0] sync2_q, sync2_d;
    logic [1:0] phase_q, phase_d;

    // Next values for the synchronizer chain and phase counter; the phase
    // restarts on the same edge the synchronized state takes a new value
    always_comb begin
        sync1_d = {data_p, data_n};
        sync2_d = sync1_q;
        if (sync1_q != sync2_q) begin
            phase_d = 2'd0;
        end else begin
            phase_d = phase_q + 2'd1;
        end
    end

    // Sampler registers; the line is assumed idle (J) out of reset
    always_ff @(posedge clock48) begin
        if (reset) begin
            sync1_q <= LS_J;
            sync2_q <= LS_J;
            phase_q <= 2'd0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            phase_q <= phase_d;
        end
    end

    assign line_state    = line_state_e'(sync2_q);
    assign sample_strobe = (phase_q == 2'd2);

endmodule

// File: rtl/usb_fs_receiver.sv
// USB full-speed receiver: SYNC detection, NRZI decode, bit unstuffing,
// LSB-first byte assembly, EOP/abort signalling and bus-reset detection.
module usb_fs_receiver
    import usb_fs_receiver_pkg::*;
#(
    parameter int RESET_CYCLES   = RESET_CYCLES_DEFAULT,
    parameter int MIN_SYNC_ZEROS = MIN_SYNC_ZEROS_DEFAULT
) (
    input  logic              clock48,
    input  logic              reset,
    input  logic              data_p,
    input  logic              data_n,
    usb_fs_receiver_if.master rx
);

    localparam logic [7:0] RESET_LIMIT = 8'(RESET_CYCLES);
    localparam logic [3:0] SYNC_MIN    = 4'(MIN_SYNC_ZEROS);

    line_state_e line_state_s;
    logic        sample_strobe_s;
    logic        dec_bit_s;
    logic        se0_s;

    rx_state_e   state_q, state_d;
    line_state_e prev_q, prev_d;
    logic [3:0]  zero_cnt_q, zero_cnt_d;
    logic [2:0]  ones_cnt_q, ones_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  shift_q, shift_d;
    logic [2:0]  idle_cnt_q, idle_cnt_d;
    logic [7:0]  se0_cnt_q, se0_cnt_d;
    logic [7:0]  byte_data_q, byte_data_d;
    logic        byte_valid_q, byte_valid_d;
    logic        packet_start_q, packet_start_d;
    logic        packet_end_q, packet_end_d;
    logic        packet_error_q, packet_error_d;
    logic        bus_reset_q, bus_reset_d;

    usb_line_sampler u_sampler (
        .clock48       (clock48),
        .reset         (reset),
        .data_p        (data_p),
        .data_n        (data_n),
        .line_state    (line_state_s),
        .sample_strobe (sample_strobe_s)
    );

    assign dec_bit_s = nrzi_decode(line_state_s, prev_q);
    assign se0_s     = (line_state_s == LS_SE0);

    // Packet FSM next state: acts only on the mid-bit sample strobe
    always_comb begin
        state_d        = state_q;
        prev_d         = prev_q;
        zero_cnt_d     = zero_cnt_q;
        ones_cnt_d     = ones_cnt_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        idle_cnt_d     = idle_cnt_q;
        byte_data_d    = byte_data_q;
        byte_valid_d   = 1'b0;
        packet_start_d = 1'b0;
        packet_end_d   = 1'b0;
        packet_error_d = 1'b0;
        if (sample_strobe_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (line_state_s == LS_K) begin
                        // The first K is already the first decoded zero of SYNC
                        state_d    = ST_SYNC;
                        prev_d     = LS_K;
                        zero_cnt_d = 4'd1;
                    end else begin
                        prev_d = LS_J;
                    end
                end
                ST_SYNC: begin
                    if ((line_state_s == LS_SE0) || (line_state_s == LS_SE1)) begin
                        state_d = ST_IDLE;
                        prev_d  = LS_J;
                    end else if (!dec_bit_s) begin
                        prev_d = line_state_s;
                        if (zero_cnt_q != 4'd15) begin
                            zero_cnt_d = zero_cnt_q + 4'd1;
                        end else begin
                            zero_cnt_d = zero_cnt_q;
                        end
                    end else if (zero_cnt_q >= SYNC_MIN) begin
                        // SYNC's closing 1 seeds the stuffing run
                        state_d        = ST_DATA;
                        prev_d         = line_state_s;
                        packet_start_d = 1'b1;
                        ones_cnt_d     = 3'd1;
                        bit_cnt_d      = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                        prev_d  = LS_J;
                    end
                end
                ST_DATA: begin
                    if (line_state_s == LS_SE0) begin
                        state_d        = ST_EOP;
                        packet_end_d   = 1'b1;
                        packet_error_d = (bit_cnt_q != 3'd0);
                    end else if (line_state_s == LS_SE1) begin
                        state_d        = ST_ABORT;
                        idle_cnt_d     = 3'd0;
                        packet_end_d   = 1'b1;
                        packet_error_d = 1'b1;
                    end else if (ones_cnt_q == 3'd6) begin
                        prev_d = line_state_s;
                        if (dec_bit_s) begin
                            // Seventh consecutive one: stuff error
                            state_d        = ST_ABORT;
                            idle_cnt_d     = 3'd0;
                            packet_end_d   = 1'b1;
                            packet_error_d = 1'b1;
                        end else begin
                            // Stuffed zero is dropped
                            ones_cnt_d = 3'd0;
                        end
                    end else begin
                        prev_d    = line_state_s;
                        shift_d   = {dec_bit_s, shift_q[6:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (dec_bit_s) begin
                            ones_cnt_d = ones_cnt_q + 3'd1;
                        end else begin
                            ones_cnt_d = 3'd0;
                        end
                        if (bit_cnt_q == 3'd7) begin
                            byte_data_d  = {dec_bit_s, shift_q};
                            byte_valid_d = 1'b1;
                        end else begin
                            byte_valid_d = 1'b0;
                        end
                    end
                end
                ST_EOP: begin
                    if ((line_state_s == LS_J) || (line_state_s == LS_K)) begin
                        state_d = ST_IDLE;
                        prev_d  = LS_J;
                    end else begin
                        state_d = ST_EOP;
                    end
                end
                ST_ABORT: begin
                    if (line_state_s != LS_J) begin
                        idle_cnt_d = 3'd0;
                    end else if (idle_cnt_q == 3'd7) begin
                        state_d    = ST_IDLE;
                        prev_d     = LS_J;
                        idle_cnt_d = 3'd0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 3'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    prev_d  = LS_J;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Bus-reset detector: saturating SE0 run length, one pulse per run
    always_comb begin
        bus_reset_d = se0_s && (se0_cnt_q == (RESET_LIMIT - 8'd1));
        if (!se0_s) begin
            se0_cnt_d = 8'd0;
        end else if (se0_cnt_q != RESET_LIMIT) begin
            se0_cnt_d = se0_cnt_q + 8'd1;
        end else begin
            se0_cnt_d = se0_cnt_q;
        end
    end

    // All receiver state and registered outputs
    always_ff @(posedge clock48) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            prev_q         <= LS_J;
            zero_cnt_q     <= 4'd0;
            ones_cnt_q     <= 3'd0;
            bit_cnt_q      <= 3'd0;
            shift_q        <= 7'd0;
            idle_cnt_q     <= 3'd0;
            se0_cnt_q      <= 8'd0;
            byte_data_q    <= 8'd0;
            byte_valid_q   <= 1'b0;
            packet_start_q <= 1'b0;
            packet_end_q   <= 1'b0;
            packet_error_q <= 1'b0;
            bus_reset_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            prev_q         <= prev_d;
            zero_cnt_q     <= zero_cnt_d;
            ones_cnt_q     <= ones_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            idle_cnt_q     <= idle_cnt_d;
            se0_cnt_q      <= se0_cnt_d;
            byte_data_q    <= byte_data_d;
            byte_valid_q   <= byte_valid_d;
            packet_start_q <= packet_start_d;
            packet_end_q   <= packet_end_d;
            packet_error_q <= packet_error_d;
            bus_reset_q    <= bus_reset_d;
        end
    end

    assign rx.byte_data    = byte_data_q;
    assign rx.byte_valid   = byte_valid_q;
    assign rx.packet_start = packet_start_q;
    assign rx.packet_end   = packet_end_q;
    assign rx.packet_error = packet_error_q;
    assign rx.bus_reset    = bus_reset_q;

endmodule
